// File: rtl/pit_ctrl_sequencer.sv
// pit_ctrl_sequencer: 3-counter PIT control word / data byte sequencer.
// Define PIT_READBACK_EN to compile in the multi-counter read-back latch command.
module pit_ctrl_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr,
    input  logic        rd,
    input  logic [1:0]  addr,
    input  logic [7:0]  data_in,
    input  logic [15:0] cnt_val0,
    input  logic [15:0] cnt_val1,
    input  logic [15:0] cnt_val2,
    output logic [5:0]  cont_word0,
    output logic [5:0]  cont_word1,
    output logic [5:0]  cont_word2,
    output logic [7:0]  cnt_data,
    output logic [2:0]  de,
    output logic [2:0]  byte_hi,
    output logic [7:0]  data_out
);
    typedef enum logic {EXP_LSB, EXP_MSB} ptr_e;
    logic [5:0]  cw_q [3];
    logic [5:0]  cw_d [3];
    ptr_e        wptr_q [3];
    ptr_e        wptr_d [3];
    ptr_e        rptr_q [3];
    ptr_e        rptr_d [3];
    logic [15:0] latch_q [3];
    logic [15:0] latch_d [3];
    logic [15:0] cv [3];
    logic [2:0]  latched_q, latched_d;
    logic [7:0]  cnt_data_q, cnt_data_d, data_out_q, data_out_d;
    logic [2:0]  de_q, de_d, byte_hi_q, byte_hi_d;
    logic [1:0]  sc, rw_cmd, rw;
    logic [15:0] src;
    logic        hi;

    assign cv[0]  = cnt_val0;
    assign cv[1]  = cnt_val1;
    assign cv[2]  = cnt_val2;
    assign sc     = data_in[7:6];
    assign rw_cmd = data_in[5:4];

    always_comb begin
        cw_d       = cw_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        latch_d    = latch_q;
        latched_d  = latched_q;
        cnt_data_d = cnt_data_q;
        data_out_d = data_out_q;
        de_d       = '0;
        byte_hi_d  = '0;
        rw         = '0;
        src        = '0;
        hi         = 1'b0;
        if (wr && addr == 2'd3) begin
            if (sc != 2'd3) begin
                if (rw_cmd != 2'b00) begin
                    cw_d[sc]      = data_in[5:0];
                    wptr_d[sc]    = EXP_LSB;
                    rptr_d[sc]    = EXP_LSB;
                    latched_d[sc] = 1'b0;
                end else if (!latched_q[sc]) begin
                    latch_d[sc]   = cv[sc];
                    latched_d[sc] = 1'b1;
                end
            end
`ifdef PIT_READBACK_EN
            else if (!data_in[5]) begin
                for (int n = 0; n < 3; n++)
                    if (data_in[n+1] && !latched_q[n]) begin
                        latch_d[n]   = cv[n];
                        latched_d[n] = 1'b1;
                    end
            end
`endif
        end else if (wr) begin
            rw = cw_q[addr][5:4];
            if (rw != 2'b00) begin
                cnt_data_d      = data_in;
                de_d[addr]      = 1'b1;
                byte_hi_d[addr] = rw == 2'b10 || (rw == 2'b11 && wptr_q[addr] == EXP_MSB);
                if (rw == 2'b11)
                    wptr_d[addr] = wptr_q[addr] == EXP_LSB ? EXP_MSB : EXP_LSB;
            end
        end else if (rd && addr == 2'd3) begin
            data_out_d = 8'h00;
        end else if (rd) begin
            rw         = cw_q[addr][5:4];
            src        = latched_q[addr] ? latch_q[addr] : cv[addr];
            hi         = rw == 2'b10 || (rw == 2'b11 && rptr_q[addr] == EXP_MSB);
            data_out_d = hi ? src[15:8] : src[7:0];
            if (rw == 2'b11)
                rptr_d[addr] = rptr_q[addr] == EXP_LSB ? EXP_MSB : EXP_LSB;
            // the latch lives until the final byte of the access sequence is read
            if (rw != 2'b00 && !(rw == 2'b11 && rptr_q[addr] == EXP_LSB))
                latched_d[addr] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cw_q       <= '{default: '0};
            wptr_q     <= '{default: EXP_LSB};
            rptr_q     <= '{default: EXP_LSB};
            latch_q    <= '{default: '0};
            latched_q  <= '0;
            cnt_data_q <= '0;
            data_out_q <= '0;
            de_q       <= '0;
            byte_hi_q  <= '0;
        end else begin
            cw_q       <= cw_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            latch_q    <= latch_d;
            latched_q  <= latched_d;
            cnt_data_q <= cnt_data_d;
            data_out_q <= data_out_d;
            de_q       <= de_d;
            byte_hi_q  <= byte_hi_d;
        end
    end

    assign cont_word0 = cw_q[0];
    assign cont_word1 = cw_q[1];
    assign cont_word2 = cw_q[2];
    assign cnt_data   = cnt_data_q;
    assign de         = de_q;
    assign byte_hi    = byte_hi_q;
    assign data_out   = data_out_q;
endmodule

// File: tb/tb_pit_ctrl_sequencer.sv
// tb_pit_ctrl_sequencer: directed + random bench with a byte-sequence reference model.
module tb_pit_ctrl_sequencer;
    logic        clk = 0, rst = 1, wr = 0, rd = 0;
    logic [1:0]  addr = 0;
    logic [7:0]  data_in = 0;
    logic [15:0] cv0 = 0, cv1 = 0, cv2 = 0;
    logic [5:0]  cw0, cw1, cw2;
    logic [7:0]  cnt_data, data_out;
    logic [2:0]  de, byte_hi;
    int total = 0, bad = 0;

    pit_ctrl_sequencer dut (
        .clk(clk), .rst(rst), .wr(wr), .rd(rd), .addr(addr), .data_in(data_in),
        .cnt_val0(cv0), .cnt_val1(cv1), .cnt_val2(cv2),
        .cont_word0(cw0), .cont_word1(cw1), .cont_word2(cw2),
        .cnt_data(cnt_data), .de(de), .byte_hi(byte_hi), .data_out(data_out)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: counts bytes written/read since the last configuration; odd count => MSB next
    logic [5:0]  m_cw [3];
    int          wcnt [3], rcnt [3];
    bit          lat [3];
    logic [15:0] lv [3];
    logic [7:0]  m_cd, m_do;
    logic [2:0]  m_de, m_bh;
    bit          go = 0;

    function automatic logic [15:0] live(int n);
        return n == 0 ? cv0 : n == 1 ? cv1 : cv2;
    endfunction

    function automatic bit is_msb(logic [1:0] rw, int k);
        return rw == 2'b10 || (rw == 2'b11 && k % 2 == 1);
    endfunction

    always @(posedge clk) begin : model
        int sc, n;
        logic [1:0] rw;
        logic [15:0] v;
        if (rst) begin
            go = 1;
            for (int i = 0; i < 3; i++) begin
                m_cw[i] = 0; wcnt[i] = 0; rcnt[i] = 0; lat[i] = 0; lv[i] = 0;
            end
            m_cd = 0; m_do = 0; m_de = 0; m_bh = 0;
        end else begin
            m_de = 0; m_bh = 0;
            if (wr && addr == 3) begin
                sc = int'(data_in[7:6]);
                if (sc < 3) begin
                    if (data_in[5:4] != 0) begin
                        m_cw[sc] = data_in[5:0]; wcnt[sc] = 0; rcnt[sc] = 0; lat[sc] = 0;
                    end else if (!lat[sc]) begin
                        lv[sc] = live(sc); lat[sc] = 1;
                    end
                end
`ifdef PIT_READBACK_EN
                else if (!data_in[5]) begin
                    for (int i = 0; i < 3; i++)
                        if (data_in[i+1] && !lat[i]) begin
                            lv[i] = live(i); lat[i] = 1;
                        end
                end
`endif
            end else if (wr) begin
                n = int'(addr);
                rw = m_cw[n][5:4];
                if (rw != 0) begin
                    m_cd = data_in; m_de[n] = 1; m_bh[n] = is_msb(rw, wcnt[n]); wcnt[n]++;
                end
            end else if (rd && addr == 3) begin
                m_do = 0;
            end else if (rd) begin
                n = int'(addr);
                rw = m_cw[n][5:4];
                v = lat[n] ? lv[n] : live(n);
                m_do = is_msb(rw, rcnt[n]) ? v[15:8] : v[7:0];
                rcnt[n]++;
                if (rw == 2'b01 || rw == 2'b10 || (rw == 2'b11 && rcnt[n] % 2 == 0)) lat[n] = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (go) begin
            chk("cont_word0", 16'(cw0), 16'(m_cw[0]));
            chk("cont_word1", 16'(cw1), 16'(m_cw[1]));
            chk("cont_word2", 16'(cw2), 16'(m_cw[2]));
            chk("cnt_data", 16'(cnt_data), 16'(m_cd));
            chk("de", 16'(de), 16'(m_de));
            chk("byte_hi", 16'(byte_hi), 16'(m_bh));
            chk("data_out", 16'(data_out), 16'(m_do));
        end
    end

    task automatic cyc(bit r, bit w, bit rr, logic [1:0] a, logic [7:0] d);
        rst = r; wr = w; rd = rr; addr = a; data_in = d;
        @(posedge clk);
        #2;
    endtask

    initial begin
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("reset_outputs", {cw0, 2'b00, de, byte_hi, 2'b00}, 16'h0000);
        chk("reset_dout", 16'(data_out), 16'h0000);
        // counter0 RW=11: LSB then MSB
        cyc(0, 1, 0, 3, 8'h34);
        cyc(0, 1, 0, 0, 8'h0F);
        chk("lsb_de", 16'(de), 16'h1);
        chk("lsb_bh", 16'(byte_hi), 16'h0);
        chk("lsb_data", 16'(cnt_data), 16'h0F);
        cyc(0, 1, 0, 0, 8'h17);
        chk("msb_de", 16'(de), 16'h1);
        chk("msb_bh", 16'(byte_hi), 16'h1);
        chk("msb_data", 16'(cnt_data), 16'h17);
        chk("cw0_34", 16'(cw0), 16'h34);
        // counter1 RW=01, back-to-back writes
        cyc(0, 1, 0, 3, 8'h50);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 1, 8'(i + 8'h40));
            chk("rw01_de", 16'(de), 16'h2);
            chk("rw01_bh", 16'(byte_hi), 16'h0);
        end
        // latch command then reads
        cv0 = 16'h1234;
        cyc(0, 1, 0, 3, 8'h00);
        cv0 = 16'h1200;
        cyc(0, 0, 1, 0, 0);
        chk("latch_lsb", 16'(data_out), 16'h34);
        cyc(0, 0, 1, 0, 0);
        chk("latch_msb", 16'(data_out), 16'h12);
        cyc(0, 0, 1, 0, 0);
        chk("live_lsb", 16'(data_out), 16'h00);
        // wr and rd together: write wins
        cyc(0, 1, 0, 3, 8'h90);
        cv2 = 16'h5A66;
        cyc(0, 0, 1, 2, 0);
        chk("rd2", 16'(data_out), 16'h66);
        cyc(0, 1, 1, 2, 8'h77);
        chk("wrrd_de", 16'(de), 16'h4);
        chk("wrrd_dout", 16'(data_out), 16'h66);
        cyc(0, 0, 1, 3, 0);
        chk("rd_addr3", 16'(data_out), 16'h00);
        // reset mid-sequence
        cyc(0, 1, 0, 0, 8'hAA);
        chk("aa_bh", 16'(byte_hi), 16'h0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 8'hBB);
        chk("bb_de", 16'(de), 16'h0);
        chk("bb_bh", 16'(byte_hi), 16'h0);
        chk("bb_cw0", 16'(cw0), 16'h00);
        // reset beats a simultaneous control write
        cyc(1, 1, 0, 3, 8'h34);
        chk("rst_prio", 16'(cw0), 16'h00);
        // read-back command
        cyc(0, 1, 0, 3, 8'h50);
        cv1 = 16'h00FF;
        cyc(0, 1, 0, 3, 8'hC4);
        cv1 = 16'h1234;
        cyc(0, 0, 1, 1, 0);
`ifdef PIT_READBACK_EN
        chk("readback", 16'(data_out), 16'h00FF);
`else
        chk("no_readback", 16'(data_out), 16'h0034);
`endif
        // random traffic
        for (int c = 0; c < 3; c++) cyc(0, 1, 0, 3, {2'(c), 2'($urandom_range(1, 3)), 4'($urandom)});
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) cv0 = 16'($urandom);
            if ($urandom_range(0, 3) == 0) cv1 = 16'($urandom);
            if ($urandom_range(0, 3) == 0) cv2 = 16'($urandom);
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0,
                2'($urandom), 8'($urandom));
        end
        cyc(0, 0, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
